// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider with tick strobe.
// Define CLKDIV_ODD_DUTY50_EN to add a negedge stage giving 50% duty on odd divisors.
module clk_div_prog #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             div_busy,
   output logic             div_ack,
   output logic             load_err,
   output logic             clk_out,
   output logic             tick,
   output logic             running
);

   localparam logic [DIV_W-1:0] C_DEF = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] C_MIN = DIV_W'(2);
   localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_n_act;
   logic [DIV_W-1:0] r_n_pend;
   logic             r_busy;
   logic             r_clk_pos;
   logic             r_tick;
   logic             r_ack;
   logic             r_err;

   logic             w_run;
   logic             w_last;
   logic             w_bnd;
   logic [DIV_W-1:0] w_half;
   logic [DIV_W-1:0] w_clamped;
   logic             w_accept;
   logic             w_apply;

   assign w_run     = (r_state == ST_RUN);
   assign w_last    = (r_cnt == (r_n_act - C_ONE));
   assign w_bnd     = w_run & w_last;
   assign w_half    = r_n_act >> 1;
   assign w_clamped = (div_val < C_MIN) ? C_MIN : div_val;
   assign w_accept  = div_load & ~r_busy;
   // A pending divisor only lands on a period boundary, or at once when idle.
   assign w_apply   = r_busy & (w_bnd | ~w_run);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (en) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last && !en) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_clk_pos <= 1'b0;
         r_tick    <= 1'b0;
      end else if (w_run) begin
         r_cnt     <= w_last ? '0 : r_cnt + C_ONE;
         r_clk_pos <= (r_cnt < w_half);
         r_tick    <= (r_cnt == '0);
      end else begin
         r_cnt     <= '0;
         r_clk_pos <= 1'b0;
         r_tick    <= 1'b0;
      end
   end

   // Accept and apply are mutually exclusive: accept needs busy low, apply needs it high.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_n_act  <= C_DEF;
         r_n_pend <= C_DEF;
         r_busy   <= 1'b0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ack <= w_apply;
         r_err <= div_load & r_busy;
         if (w_apply) begin
            r_n_act <= r_n_pend;
            r_busy  <= 1'b0;
         end else if (w_accept) begin
            r_n_pend <= w_clamped;
            r_busy   <= 1'b1;
         end
      end
   end

`ifdef CLKDIV_ODD_DUTY50_EN
   logic r_clk_neg;

   always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_clk_neg <= 1'b0;
      end else begin
         r_clk_neg <= r_clk_pos;
      end
   end

   // Stretching by half a source period only on odd divisors keeps the rise on tick.
   assign clk_out = r_n_act[0] ? (r_clk_pos | r_clk_neg) : r_clk_pos;
`else
   assign clk_out = r_clk_pos;
`endif

   assign tick     = r_tick;
   assign running  = w_run;
   assign div_busy = r_busy;
   assign div_ack  = r_ack;
   assign load_err = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - self-checking bench for clk_div_prog.
module tb_clk_div_prog;

   logic       clk_in = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] div_val;
   logic       div_load;
   logic       div_busy, div_ack, load_err, clk_out, tick, running;

   int checks = 0;
   int errors = 0;

   clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .en(en), .div_val(div_val), .div_load(div_load),
      .div_busy(div_busy), .div_ack(div_ack), .load_err(load_err),
      .clk_out(clk_out), .tick(tick), .running(running)
   );

   always #5 clk_in = ~clk_in;

   // Reference model: period start time plus a one-deep pending queue.
   int  k, m_start, m_nact;
   bit  m_run;
   int  q[$];
   bit  e_pos, e_pos_prev, e_clk, e_tick, e_ack, e_err;

   task automatic model_reset();
      k = 0; m_start = 0; m_nact = 2; m_run = 0; q.delete();
      e_pos = 0; e_pos_prev = 0; e_clk = 0; e_tick = 0; e_ack = 0; e_err = 0;
   endtask

   task automatic model_edge(input logic e, input logic l, input logic [7:0] v);
      int ph;
      bit bnd, busy_old;
      ph = k - m_start;
      bnd = m_run && (ph == m_nact - 1);
      e_pos_prev = e_pos;
      e_pos = m_run && (ph < m_nact / 2);
      e_tick = m_run && (ph == 0);
      busy_old = (q.size() != 0);
      e_err = l && busy_old;
      e_ack = 0;
      if (busy_old && (bnd || !m_run)) begin
         m_nact = q.pop_front();
         e_ack = 1;
      end
      if (l && !busy_old) q.push_back((v < 2) ? 2 : int'(v));
      if (!m_run) begin
         if (e) begin m_run = 1; m_start = k + 1; end
      end else if (bnd) begin
         if (e) m_start = k + 1;
         else m_run = 0;
      end
`ifdef CLKDIV_ODD_DUTY50_EN
      e_clk = e_pos || ((m_nact % 2 == 1) && e_pos_prev);
`else
      e_clk = e_pos;
`endif
      k++;
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic compare_model();
      chk("clk_out", clk_out, e_clk);
      chk("tick", tick, e_tick);
      chk("running", running, m_run);
      chk("div_busy", div_busy, q.size() != 0);
      chk("div_ack", div_ack, e_ack);
      chk("load_err", load_err, e_err);
   endtask

   // Called at a negedge; returns at the following negedge.
   task automatic step(input logic e, input logic l, input logic [7:0] v);
      en = e; div_load = l; div_val = v;
      @(posedge clk_in);
      model_edge(e, l, v);
      #1;
      compare_model();
      @(negedge clk_in);
      div_load = 1'b0;
   endtask

   task automatic wait_ack(input string nm, output int errs_seen, output bit busy_ok);
      bit got;
      got = 0; errs_seen = 0; busy_ok = 1;
      for (int i = 0; i < 60 && !got; i++) begin
         step(1'b1, 1'b0, 8'd0);
         if (load_err) errs_seen++;
         if (div_ack) got = 1;
         else if (!div_busy) busy_ok = 0;
      end
      chk(nm, got, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_clk"}, clk_out, 1'b0);
      chk({nm, "_tick"}, tick, 1'b0);
      chk({nm, "_run"}, running, 1'b0);
      chk({nm, "_busy"}, div_busy, 1'b0);
      chk({nm, "_ack"}, div_ack, 1'b0);
      chk({nm, "_err"}, load_err, 1'b0);
   endtask

   typedef struct {
      logic       en, ld;
      logic [7:0] val;
      logic       clk, tk, run, busy, ack, err;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int  highs, ticks, errs_seen, n, pat;
      bit  busy_ok;
      logic ren, rld;

      tbl[0] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 8'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = 8'd0;
      model_reset();
      @(negedge clk_in); @(negedge clk_in);
      chk_reset_outputs("reset");
      rst_n = 1'b1;

      // Default divisor, then clamped load of 0 and a dropped colliding load of 9.
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].en, tbl[i].ld, tbl[i].val);
         chk($sformatf("tbl%0d_clk", i), clk_out, tbl[i].clk);
         chk($sformatf("tbl%0d_tick", i), tick, tbl[i].tk);
         chk($sformatf("tbl%0d_run", i), running, tbl[i].run);
         chk($sformatf("tbl%0d_busy", i), div_busy, tbl[i].busy);
         chk($sformatf("tbl%0d_ack", i), div_ack, tbl[i].ack);
         chk($sformatf("tbl%0d_err", i), load_err, tbl[i].err);
      end

      // Odd divisor 5.
      step(1'b1, 1'b1, 8'd5);
      wait_ack("ack_div5", errs_seen, busy_ok);
      highs = 0; ticks = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 8'd0);
         highs += int'(clk_out); ticks += int'(tick);
      end
`ifdef CLKDIV_ODD_DUTY50_EN
      chk_int("div5_high_samples", highs, 3);
`else
      chk_int("div5_high_samples", highs, 2);
`endif
      chk_int("div5_ticks", ticks, 1);

      // Collision: 8 accepted, 3 dropped.
      step(1'b1, 1'b1, 8'd8);
      step(1'b1, 1'b1, 8'd3);
      n = int'(load_err);
      wait_ack("ack_div8", errs_seen, busy_ok);
      chk_int("collision_err_pulses", n + errs_seen, 1);
      chk("collision_busy_held", busy_ok, 1'b1);
      highs = 0; ticks = 0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 8'd0);
         highs += int'(clk_out); ticks += int'(tick);
      end
      chk_int("div8_highs", highs, 8);
      chk_int("div8_ticks", ticks, 2);

      // Clean stop with N=6 at cnt=1, then full first period on restart.
      step(1'b1, 1'b1, 8'd6);
      wait_ack("ack_div6", errs_seen, busy_ok);
      for (int i = 0; i < 20 && (k - m_start) != 1; i++) step(1'b1, 1'b0, 8'd0);
      n = 0;
      do begin
         step(1'b0, 1'b0, 8'd0);
         n++;
      end while (running && n < 20);
      chk_int("stop_edges", n, 5);
      highs = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 8'd0);
         highs += int'(clk_out) + int'(tick) + int'(running);
      end
      chk_int("stopped_quiet", highs, 0);
      step(1'b1, 1'b0, 8'd0);
      chk("restart_running", running, 1'b1);
      chk("restart_clk_low", clk_out, 1'b0);
      pat = 0; ticks = 0;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 8'd0);
         pat = (pat << 1) | int'(clk_out);
         ticks += int'(tick);
      end
      chk_int("restart_pattern", pat, 6'b111000);
      chk_int("restart_ticks", ticks, 1);

      // Reset with a load pending.
      step(1'b1, 1'b1, 8'd20);
      chk("pending_busy", div_busy, 1'b1);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      en = 1'b0;
      @(negedge clk_in); @(negedge clk_in);
      chk_reset_outputs("midreset_hold");
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'd0);

      // Randomised stimulus against the model.
      ren = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 29) == 0) ren = ~ren;
         rld = ($urandom_range(0, 6) == 0);
         step(ren, rld, 8'($urandom_range(0, 12)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider: the parametrised successor of the fixed divide-by-N clock divider in the clocking subsystem. It divides `clk_in` by any integer N from 2 to 2^DIV_W−1, odd or even. The divisor can be changed on the fly without glitches or runt pulses, and the output can be stopped and started cleanly. A single-cycle `tick` strobe is provided so downstream logic can stay in the `clk_in` domain instead of clocking off `clk_out`.

## Interface
Parameters:
- `DIV_W`, default 8, width of the divisor.
- `DEFAULT_DIV`, default 2, divisor active after reset. Must be at least 2.

Ports:
- `clk_in` — input, 1 — source clock.
- `rst_n` — input, 1 — reset, asynchronous, active-low.
- `en` — input, 1 — run request. Level-sensitive.
- `div_val` — input, DIV_W — requested divisor. Sampled only when `div_load` is accepted.
- `div_load` — input, 1 — one-cycle load strobe.
- `div_busy` — output, 1 — a divisor is pending and has not yet been applied.
- `div_ack` — output, 1 — one-cycle pulse on the edge where the pending divisor becomes active.
- `load_err` — output, 1 — one-cycle pulse when a `div_load` arrives while `div_busy` is high.
- `clk_out` — output, 1 — divided clock. Driven from a register.
- `tick` — output, 1 — one-cycle pulse coincident with each rising edge of `clk_out`.
- `running` — output, 1 — divider is counting, i.e. not idle.

## Operation
- **State:** `cnt` (DIV_W bits), `n_act` (active divisor), `n_pend` (pending divisor) plus its pending flag, and the `running` flag.
- **Half-period:** H = floor(n_act/2).
- **Counting while running:** `cnt` cycles 0 → n_act−1 → 0.
  - `clk_out`(t+1) = (`cnt`(t) < H).
  - `tick`(t+1) = (`cnt`(t) == 0).
- **Clamping:** a `div_val` below 2 is stored as 2. No other range checks.
- **Load handshake:**
  - `div_load` with `div_busy` low is accepted: `n_pend` ← clamped `div_val`, and `div_busy` is high from the next cycle.
  - `div_load` with `div_busy` high is dropped, and `load_err` pulses the next cycle.
- **Apply point:** the pending divisor is applied only at a period boundary, i.e. the edge where `running` is high and `cnt`(t) == n_act−1. On that edge:
  - `cnt` → 0,
  - `n_act` ← `n_pend`,
  - `div_busy` → 0,
  - `div_ack` = 1 for one cycle.
- **Apply while idle:** the pending divisor is applied on the next edge after acceptance.
- **Same-cycle case:** a load accepted in the same cycle as a boundary takes effect at the following boundary, not at that one.
- **Stop:** when `en` falls, the current period completes. At the boundary, `running` → 0, `cnt` holds 0, and `clk_out` and `tick` stay 0.
- **Start:** when `en` is high while idle, `running` → 1 on the next edge. Counting then proceeds exactly as after reset, with the first `clk_out` rise one edge later.
- **Mid-operation reset:** asserting `rst_n` low immediately restores all reset values and discards any pending load.

## Timing
- **Reset values:**
  - `cnt` = 0,
  - `n_act` = `DEFAULT_DIV`,
  - `clk_out` = 0, `tick` = 0, `div_busy` = 0, `div_ack` = 0, `load_err` = 0, `running` = 0.
- **Start latency:** `running` rises on the first edge with `en` high. `clk_out` and `tick` rise on the following edge.
- **Period:** exactly n_act `clk_in` cycles.
  - Even N: high for N/2 cycles.
  - Odd N: high for (N−1)/2 cycles, low for (N+1)/2 cycles, unless `CLKDIV_ODD_DUTY50_EN` is defined.
- **Glitch-free change:** no high or low phase is ever shorter than min(old H, new H) `clk_in` cycles across a divisor change.
- **Worst-case load-to-ack latency:** n_act + 1 cycles.

## Configuration
- **`CLKDIV_ODD_DUTY50_EN` defined:**
  - A negedge-`clk_in` register holds a copy of the posedge `clk_out` register.
  - `clk_out` is the OR of the two registers when n_act is odd, and the posedge register alone when n_act is even.
  - Result: odd divisors have a high time of N/2 `clk_in` periods, i.e. exactly 50% duty, with the rise still aligned to `tick`.
  - The negedge register also resets to 0.
- **`CLKDIV_ODD_DUTY50_EN` not defined:**
  - No negedge logic is built.
  - Odd divisors use the (N−1)/2 high, (N+1)/2 low duty.

## Test plan
- **Default divisor:** reset, then `en`=1 with `DEFAULT_DIV`=2. Required: `running` rises at edge 1; `clk_out` is 1,0,1,0 from edge 2; `tick` pulses every 2 cycles; all flags stay 0.
- **Odd divisor, macro off:** load 5. Required: `div_ack` pulses at the boundary; `clk_out` is high 2 cycles and low 3 cycles.
- **Odd divisor, macro on:** load 5. Required: `clk_out` is high for 2.5 `clk_in` periods.
- **Load collision:** load 8, then load 3 one cycle later. Required: `load_err` pulses once; `div_busy` stays high until the boundary; the 8 is applied and the 3 is lost.
- **Clean stop:** with N=6, drop `en` at `cnt`=1. Required: the period completes, `running` falls at the boundary, and `clk_out` stays 0. Raise `en` again and require a full first period.
- **Clamp and reset:** load `div_val`=0 and require period 2 after `div_ack`. Then assert `rst_n` with a load pending and require all outputs at reset values with `div_busy`=0.
